// File: rtl/lisnoc16_usb_upstream_scheduler_if.sv
// Bundle between the per-channel USB packet buffers, the upstream scheduler and the USB TX FIFO.
// master = scheduler side, slave = buffers/FIFO side.
`ifndef FLIT16_WIDTH
`define FLIT16_WIDTH 18
`endif
`ifndef FLIT16_TYPE_MSB
`define FLIT16_TYPE_MSB 17
`endif
`ifndef FLIT16_TYPE_LSB
`define FLIT16_TYPE_LSB 16
`endif
`ifndef LD_MAX_NOC16_PACKET_LENGTH
`define LD_MAX_NOC16_PACKET_LENGTH 4
`endif

interface lisnoc16_usb_upstream_scheduler_if #(
  parameter int vchannels = 3,
  parameter int ch_width = (vchannels > 1) ? $clog2(vchannels) : 1
);
  logic [vchannels*`FLIT16_WIDTH-1:0]              buf_flit;
  logic [vchannels-1:0]                            buf_valid;
  logic [vchannels*`LD_MAX_NOC16_PACKET_LENGTH-1:0] buf_length;
  logic [vchannels-1:0]                            buf_ready;
  logic [15:0]                                     usb_data;
  logic                                            usb_valid;
  logic                                            usb_last;
  logic                                            usb_ready;
  logic [ch_width-1:0]                             active_ch;
  logic                                            err_length;

  modport master (
    input  buf_flit, buf_valid, buf_length, usb_ready,
    output buf_ready, usb_data, usb_valid, usb_last, active_ch, err_length
  );

  modport slave (
    output buf_flit, buf_valid, buf_length, usb_ready,
    input  buf_ready, usb_data, usb_valid, usb_last, active_ch, err_length
  );
endinterface

// File: rtl/lisnoc16_usb_upstream_scheduler.sv
// Round-robin scheduler from per-VC USB packet buffers onto the 16-bit USB TX stream.
// Define LISNOC16_USB_SCHED_HEADER_EN to prefix each packet with a {channel, length} header word.
`ifndef FLIT16_WIDTH
`define FLIT16_WIDTH 18
`endif
`ifndef FLIT16_TYPE_MSB
`define FLIT16_TYPE_MSB 17
`endif
`ifndef FLIT16_TYPE_LSB
`define FLIT16_TYPE_LSB 16
`endif
`ifndef LD_MAX_NOC16_PACKET_LENGTH
`define LD_MAX_NOC16_PACKET_LENGTH 4
`endif

module lisnoc16_usb_upstream_scheduler #(
  parameter int vchannels = 3,
  parameter int ch_width = (vchannels > 1) ? $clog2(vchannels) : 1
) (
  input logic clk,
  input logic rst,
  lisnoc16_usb_upstream_scheduler_if.master bus
);
  localparam int fw = `FLIT16_WIDTH;
  localparam int ld = `LD_MAX_NOC16_PACKET_LENGTH;
  localparam int cw = ld + 1;
  localparam logic [1:0] type_last   = 2'b10;
  localparam logic [1:0] type_single = 2'b11;

`ifdef LISNOC16_USB_SCHED_HEADER_EN
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t              state, state_nx;
  logic [ch_width-1:0] ptr, active, grant;
  logic                grant_ok;
  logic [ch_width:0]   sum;
  logic [cw-1:0]       count;
  logic                err;
  logic [fw-1:0]       sel_flit;
  logic                sel_valid;
  logic [ld-1:0]       grant_len;
  logic [1:0]          sel_type;
  logic                flit_is_end;
  logic                accept;
  logic [vchannels-1:0] ready;
  logic [15:0]         data;
  logic                valid;
  logic                last;

  // Search upward from ptr with wrap; iterating downward lets the nearest candidate win.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    sum      = '0;
    for (int i = vchannels - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (ch_width+1)'(i);
      if (sum >= (ch_width+1)'(vchannels)) sum = sum - (ch_width+1)'(vchannels);
      if (bus.buf_valid[sum[ch_width-1:0]]) begin
        grant    = sum[ch_width-1:0];
        grant_ok = 1'b1;
      end
    end
  end

  always_comb begin
    sel_flit  = '0;
    sel_valid = 1'b0;
    grant_len = '0;
    for (int c = 0; c < vchannels; c++) begin
      if (active == ch_width'(c)) begin
        sel_flit  = bus.buf_flit[c*fw +: fw];
        sel_valid = bus.buf_valid[c];
      end
      if (grant == ch_width'(c)) grant_len = bus.buf_length[c*ld +: ld];
    end
  end

  assign sel_type    = sel_flit[`FLIT16_TYPE_MSB:`FLIT16_TYPE_LSB];
  assign flit_is_end = (sel_type == type_last) || (sel_type == type_single);
  assign accept      = (state == DATA) && sel_valid && bus.usb_ready;

  always_comb begin
    state_nx = state;
    valid    = 1'b0;
    data     = '0;
    last     = 1'b0;
    ready    = '0;
    case (state)
      IDLE: begin
`ifdef LISNOC16_USB_SCHED_HEADER_EN
        if (grant_ok) state_nx = HEADER;
`else
        if (grant_ok) state_nx = DATA;
`endif
      end
`ifdef LISNOC16_USB_SCHED_HEADER_EN
      HEADER: begin
        valid = 1'b1;
        data  = {4'(active), 12'(count)};
        if (bus.usb_ready) state_nx = DATA;
      end
`endif
      DATA: begin
        valid = sel_valid;
        data  = sel_flit[15:0];
        last  = (count == cw'(1));
        for (int c = 0; c < vchannels; c++)
          ready[c] = (active == ch_width'(c)) && bus.usb_ready;
        if (accept && count == cw'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      active <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant_ok) begin
        active <= grant;
        // A zero length field encodes the maximum packet size.
        count  <= (grant_len == '0) ? {1'b1, {ld{1'b0}}} : {1'b0, grant_len};
      end
      if (accept) begin
        count <= count - cw'(1);
        if (count == cw'(1))
          ptr <= (active == ch_width'(vchannels - 1)) ? '0 : active + ch_width'(1);
        if ((flit_is_end && count > cw'(1)) || (!flit_is_end && count == cw'(1)))
          err <= 1'b1;
      end
    end
  end

  assign bus.buf_ready  = ready;
  assign bus.usb_data   = data;
  assign bus.usb_valid  = valid;
  assign bus.usb_last   = last;
  assign bus.active_ch  = active;
  assign bus.err_length = err;
endmodule

// File: tb/tb_lisnoc16_usb_upstream_scheduler.sv
// Self-checking bench: directed table, corner-case sequences and a randomized round-robin model.
`ifndef FLIT16_WIDTH
`define FLIT16_WIDTH 18
`endif
`ifndef LD_MAX_NOC16_PACKET_LENGTH
`define LD_MAX_NOC16_PACKET_LENGTH 4
`endif

module tb_lisnoc16_usb_upstream_scheduler;
  localparam int NV = 3;
  localparam int FW = `FLIT16_WIDTH;
  localparam int LD = `LD_MAX_NOC16_PACKET_LENGTH;
`ifdef LISNOC16_USB_SCHED_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [1:0]  ch;
    logic        last;
    logic [15:0] data;
  } word_t;

  typedef struct {
    int          ch;
    int          len;
    logic [15:0] base;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_pops;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lisnoc16_usb_upstream_scheduler_if #(.vchannels(NV)) bus();
  lisnoc16_usb_upstream_scheduler #(.vchannels(NV)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [FW-1:0] fq[NV][$];
  int            lq[NV][$];
  int            popped[NV];
  logic [15:0]   rq[NV][$];
  int            rlq[NV][$];
  word_t         obs_q[$];
  word_t         exp_q[$];
  int            popcnt[NV];
  int            total = 0, passed = 0;
  int            stable_err = 0, onehot_err = 0;
  int            rmode = 0;
  logic          usb_ready_v = 1'b1;
  logic          held = 1'b0;
  word_t         held_w;
  vec_t          vt[3];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  task automatic drive();
    for (int c = 0; c < NV; c++) begin
      bus.buf_valid[c]           = (lq[c].size() > 0);
      bus.buf_flit[c*FW +: FW]   = (fq[c].size() > 0) ? fq[c][0] : '0;
      bus.buf_length[c*LD +: LD] = (lq[c].size() > 0) ? LD'(lq[c][0]) : '0;
    end
    bus.usb_ready = usb_ready_v;
  endtask

  task automatic push_pkt(int ch, int len, logic [15:0] base, bit rnd, bit bad_first);
    logic [15:0] d;
    logic [1:0]  ty;
    for (int i = 0; i < len; i++) begin
      d  = rnd ? 16'($urandom) : base + 16'(i);
      ty = (len == 1) ? 2'b11 : (i == len - 1) ? 2'b10 : (i == 0) ? 2'b01 : 2'b00;
      if (bad_first && i == 0) ty = 2'b10;
      fq[ch].push_back({ty, d});
      if (rnd) rq[ch].push_back(d);
    end
    lq[ch].push_back(len);
    if (rnd) rlq[ch].push_back(len);
    drive();
  endtask

  task automatic exp_pkt(int ch, int len, logic [15:0] base);
    word_t w;
    if (HDR != 0) begin
      w.ch = 2'(ch); w.last = 1'b0; w.data = {4'(ch), 12'(len)};
      exp_q.push_back(w);
    end
    for (int i = 0; i < len; i++) begin
      w.ch = 2'(ch); w.last = (i == len - 1); w.data = base + 16'(i);
      exp_q.push_back(w);
    end
  endtask

  task automatic cycle();
    logic [NV-1:0] pops;
    word_t w;
    @(negedge clk);
    pops = '0;
    if (!rst) begin
      if ($countones(bus.buf_ready) > 1) onehot_err++;
      for (int c = 0; c < NV; c++) popcnt[c] += int'(bus.buf_ready[c]);
      pops = bus.buf_ready;
      if (held && !(bus.usb_valid && bus.usb_data == held_w.data && bus.usb_last == held_w.last))
        stable_err++;
      w.ch = bus.active_ch; w.last = bus.usb_last; w.data = bus.usb_data;
      if (bus.usb_valid && bus.usb_ready) obs_q.push_back(w);
      held   = bus.usb_valid && !bus.usb_ready;
      held_w = w;
    end else held = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < NV; c++) begin
      if (pops[c] && fq[c].size() > 0 && lq[c].size() > 0) begin
        void'(fq[c].pop_front());
        popped[c]++;
        if (popped[c] == lq[c][0]) begin
          void'(lq[c].pop_front());
          popped[c] = 0;
        end
      end
    end
    case (rmode)
      1:       usb_ready_v = ~usb_ready_v;
      2:       usb_ready_v = ($urandom_range(0, 3) != 0);
      default: usb_ready_v = 1'b1;
    endcase
    drive();
  endtask

  task automatic run_until(int n, int budget, string name);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    if (obs_q.size() < n) chk({name, " timeout"}, obs_q.size(), n);
  endtask

  task automatic compare_stream(string name);
    chk({name, " count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk($sformatf("%s[%0d]", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_bufs();
    for (int c = 0; c < NV; c++) begin
      fq[c].delete(); lq[c].delete(); rq[c].delete(); rlq[c].delete();
      popped[c] = 0; popcnt[c] = 0;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bufs();
    cycle();
    cycle();
    rst = 1'b0;
    obs_q.delete(); exp_q.delete();
    stable_err = 0; onehot_err = 0;
  endtask

  // Reference: plain round-robin walk over the preloaded packet lists.
  task automatic build_rr_expect();
    int ptr = 0, c, len;
    bit any;
    word_t w;
    forever begin
      any = 0;
      c = 0;
      for (int k = 0; k < NV; k++)
        if (!any && rlq[(ptr + k) % NV].size() > 0) begin
          c = (ptr + k) % NV;
          any = 1;
        end
      if (!any) break;
      len = rlq[c].pop_front();
      if (HDR != 0) begin
        w.ch = 2'(c); w.last = 1'b0; w.data = {4'(c), 12'(len)};
        exp_q.push_back(w);
      end
      for (int i = 0; i < len; i++) begin
        w.ch = 2'(c); w.last = (i == len - 1); w.data = rq[c].pop_front();
        exp_q.push_back(w);
      end
      ptr = (c + 1) % NV;
    end
  endtask

  initial begin
    int lastcnt, want, exp_pops[NV];
    rst = 1'b1;
    clear_bufs();
    cycle();
    cycle();
    chk("reset usb_valid", 32'(bus.usb_valid), 0);
    chk("reset usb_last", 32'(bus.usb_last), 0);
    chk("reset usb_data", 32'(bus.usb_data), 0);
    chk("reset buf_ready", 32'(bus.buf_ready), 0);
    chk("reset active_ch", 32'(bus.active_ch), 0);
    chk("reset err_length", 32'(bus.err_length), 0);
    rst = 1'b0;

    vt[0] = '{0, 3, 16'hA001, (HDR != 0) ? 16'h0003 : 16'hA001, 16'hA003, 3};
    vt[1] = '{2, 1, 16'h5550, (HDR != 0) ? 16'h2001 : 16'h5550, 16'h5550, 1};
    vt[2] = '{1, 16, 16'h1000, (HDR != 0) ? 16'h1010 : 16'h1000, 16'h100F, 16};
    for (int v = 0; v < 3; v++) begin
      obs_q.delete();
      for (int c = 0; c < NV; c++) popcnt[c] = 0;
      push_pkt(vt[v].ch, vt[v].len, vt[v].base, 0, 0);
      run_until(vt[v].len + HDR, 200, $sformatf("vec%0d", v));
      if (obs_q.size() == vt[v].len + HDR) begin
        lastcnt = 0;
        foreach (obs_q[i]) lastcnt += int'(obs_q[i].last);
        chk($sformatf("vec%0d first word", v), 32'(obs_q[0].data), 32'(vt[v].exp_first));
        chk($sformatf("vec%0d final word", v), 32'(obs_q[obs_q.size()-1].data), 32'(vt[v].exp_last));
        chk($sformatf("vec%0d final last", v), 32'(obs_q[obs_q.size()-1].last), 1);
        chk($sformatf("vec%0d last count", v), lastcnt, 1);
        chk($sformatf("vec%0d channel", v), 32'(obs_q[obs_q.size()-1].ch), 32'(vt[v].ch));
      end
      cycle();
      chk($sformatf("vec%0d pops", v), popcnt[vt[v].ch], vt[v].exp_pops);
    end

    // Three channels valid together from reset: ch0, ch1, ch2, then back to ch0.
    do_reset();
    push_pkt(0, 1, 16'h0100, 0, 0);
    push_pkt(0, 1, 16'h0200, 0, 0);
    push_pkt(1, 2, 16'h1100, 0, 0);
    push_pkt(2, 1, 16'h2100, 0, 0);
    exp_pkt(0, 1, 16'h0100);
    exp_pkt(1, 2, 16'h1100);
    exp_pkt(2, 1, 16'h2100);
    exp_pkt(0, 1, 16'h0200);
    want = exp_q.size();
    run_until(want, 200, "rr");
    compare_stream("rr");

    // usb_ready toggling every cycle during a length-4 packet.
    stable_err = 0;
    for (int c = 0; c < NV; c++) popcnt[c] = 0;
    rmode = 1;
    push_pkt(1, 4, 16'hB000, 0, 0);
    exp_pkt(1, 4, 16'hB000);
    run_until(4 + HDR, 200, "toggle");
    rmode = 0;
    cycle();
    compare_stream("toggle");
    chk("toggle stable", stable_err, 0);
    chk("toggle pops", popcnt[1], 4);

    // New request on ch0 while ch1 is mid-packet must wait for ch1 to finish.
    push_pkt(1, 5, 16'hC000, 0, 0);
    run_until(HDR + 2, 200, "midpkt start");
    push_pkt(0, 2, 16'hC100, 0, 0);
    exp_pkt(1, 5, 16'hC000);
    exp_pkt(0, 2, 16'hC100);
    run_until(exp_q.size(), 300, "midpkt");
    compare_stream("midpkt");

    // Length says 2 but first flit is typed LAST.
    chk("err before", 32'(bus.err_length), 0);
    push_pkt(2, 2, 16'hD000, 0, 1);
    run_until(HDR + 1, 200, "err first");
    chk("err after bad flit", 32'(bus.err_length), 1);
    exp_pkt(2, 2, 16'hD000);
    run_until(HDR + 2, 200, "err pkt");
    for (int i = 0; i < 4; i++) cycle();
    compare_stream("err pkt");
    chk("err sticky", 32'(bus.err_length), 1);

    // Reset during word 2 of 4; pointer must return to 0 afterwards.
    push_pkt(1, 1, 16'hE000, 0, 0);
    exp_pkt(1, 1, 16'hE000);
    run_until(HDR + 1, 200, "pre rst");
    compare_stream("pre rst");
    push_pkt(0, 4, 16'hE100, 0, 0);
    run_until(HDR + 1, 200, "rst mid");
    chk("rst mid word2 valid", 32'(bus.usb_valid), 1);
    rst = 1'b1;
    clear_bufs();
    cycle();
    chk("rst usb_valid", 32'(bus.usb_valid), 0);
    chk("rst buf_ready", 32'(bus.buf_ready), 0);
    chk("rst active_ch", 32'(bus.active_ch), 0);
    chk("rst usb_last", 32'(bus.usb_last), 0);
    chk("rst err_length", 32'(bus.err_length), 0);
    rst = 1'b0;
    obs_q.delete(); exp_q.delete();
    push_pkt(1, 1, 16'hF100, 0, 0);
    push_pkt(2, 1, 16'hF200, 0, 0);
    exp_pkt(1, 1, 16'hF100);
    exp_pkt(2, 1, 16'hF200);
    run_until(exp_q.size(), 200, "post rst");
    compare_stream("post rst");

    // Randomized preloads with random back-pressure against the round-robin model.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int c = 0; c < NV; c++) begin
        exp_pops[c] = 0;
        for (int p = $urandom_range(0, 3); p > 0; p--) begin
          want = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(1, 6);
          exp_pops[c] += want;
          push_pkt(c, want, 16'h0, 1, 0);
        end
      end
      build_rr_expect();
      rmode = 2;
      run_until(exp_q.size(), 3000, $sformatf("rand%0d", it));
      rmode = 0;
      cycle();
      compare_stream($sformatf("rand%0d", it));
      chk($sformatf("rand%0d stable", it), stable_err, 0);
      chk($sformatf("rand%0d onehot", it), onehot_err, 0);
      chk($sformatf("rand%0d err", it), 32'(bus.err_length), 0);
      for (int c = 0; c < NV; c++)
        chk($sformatf("rand%0d pops ch%0d", it, c), popcnt[c], exp_pops[c]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lisnoc16_usb_upstream_scheduler.md
Name: lisnoc16_usb_upstream_scheduler

Overview:
- Round-robin scheduler sitting between the per-virtual-channel USB packet buffers (NoC→host direction) and the 16-bit USB transmit FIFO.
- Grants one buffer that holds a complete packet and prefixes a header word carrying channel index and packet length.
- Streams the packet's flit payloads, then releases the grant.
- Guarantees packets from different channels never interleave on the USB stream.

Parameters:
- vchannels, 3, number of packet buffers served; legal range 1..16.
- ch_width, $clog2(vchannels) (min 1), width of channel index fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- buf_flit  in  vchannels*`FLIT16_WIDTH  head flit of each buffer; channel c at slice c.
- buf_valid  in  vchannels  buffer c holds at least one complete packet.
- buf_length  in  vchannels*`LD_MAX_NOC16_PACKET_LENGTH  flit count of buffer c's head packet.
- buf_ready  out  vchannels  pop strobe qualifier; at most one bit set.
- usb_data  out  16  word to USB FIFO.
- usb_valid  out  1  usb_data valid.
- usb_last  out  1  final word of the current packet.
- usb_ready  in  1  USB FIFO accepts the word.
- active_ch  out  ch_width  currently granted channel.
- err_length  out  1  sticky: flit type disagreed with buf_length.

Behaviour:
- Reset values: buf_ready=0, usb_valid=0, usb_last=0, usb_data=0, active_ch=0, err_length=0. FSM=IDLE, round-robin pointer=0, flit counter=0.
- FSM states and transitions:
  - IDLE: if any buf_valid, pick the first set bit searching from the pointer upward with wrap. Register the grant into active_ch. Latch buf_length[active] into the counter. Go to HEADER, or DATA when the header is compiled out. No output this cycle, so arbitration latency is 1 cycle.
  - HEADER: usb_valid=1, usb_data={channel[3:0] zero-extended, length zero-extended to 12 bits}. Stay in HEADER while usb_ready=0, with the word held stable. On usb_ready go to DATA.
  - DATA: usb_data=buf_flit[active][15:0]. usb_valid=buf_valid[active]; the buffer presents out_valid for the whole packet, so this stays high. buf_ready[active]=usb_ready. Each accepted word (valid&ready) pops one flit and decrements the counter. usb_last=1 when counter==1. When the word with counter==1 is accepted: pointer=active+1 (wrap to 0 past vchannels-1), go to IDLE.
- Flit type bits `FLIT16_TYPE_MSB:`FLIT16_TYPE_LSB are not transmitted.
- Consistency check on every accepted flit:
  - type LAST or SINGLE while counter>1 → set err_length.
  - counter==1 but type not LAST/SINGLE → set err_length.
  - Packet framing always follows the latched length. err_length clears only on rst.
- No grant may change mid-packet, whatever the other buf_valid bits do.
- buf_ready is combinational from usb_ready and the state; it is never asserted in IDLE or HEADER.
- Length field is a full count. A value of 0 is treated as the maximum, 2^`LD_MAX_NOC16_PACKET_LENGTH, and does not underflow.
- Back-pressure: usb_valid, once asserted, holds data stable until accepted (AXI-style).
- Reset mid-packet returns to IDLE next cycle with all outputs at reset values. The partial packet is not completed; the upstream buffers are reset by the same rst.
- vchannels=1: arbitration is trivial, and the pointer stays 0.

Optional Feature:
- Macro: LISNOC16_USB_SCHED_HEADER_EN.
- Defined: HEADER state present; each packet is preceded by the header word.
- Undefined: HEADER state removed; IDLE goes straight to DATA. The host relies on usb_last for framing. Minimum per-packet overhead becomes 1 idle cycle, not 2.

Test Plan:
- Single channel 0, length 3, flits 0xA001/0xA002/0xA003, usb_ready=1 → header 0x0003, then 0xA001, 0xA002, 0xA003. usb_last only on 0xA003. buf_ready[0] high exactly 3 cycles.
- Channels 0,1,2 all valid (lengths 1,2,1) from reset → headers in order 0x0001, 0x1002, 0x2001. Next grant after ch2 is ch0.
- usb_ready toggled 0/1 every cycle during a length-4 packet → every word held stable while not ready. No flit dropped or duplicated. Exactly 4 pops.
- ch1 mid-packet (2 of 5 sent) while ch0 asserts valid → ch1 finishes all 5 flits before ch0's header appears.
- buf_length=2 but first flit type LAST → err_length=1 after that flit. Two data words still sent. err_length stays 1 until rst.
- rst asserted during DATA word 2 of 4 → next cycle usb_valid=0, buf_ready=0, active_ch=0. Fresh packet afterwards starts with a header and pointer=0.
